// File: rtl/latch_arbiter.sv
// Round-robin owner of a shared 8-bit register bank for four requesters.
// A grant loads the owner's byte, holds the bank for HOLD cycles, then releases it.
module latch_arbiter #(
  parameter int HOLD = 3
) (
  input  logic        CLK,
  input  logic        Clrn,
  input  logic [3:0]  Req,
  input  logic [31:0] Din,
  input  logic        Flush,
  output logic [3:0]  Grant,
  output logic [3:0]  Ack,
  output logic [7:0]  Q,
  output logic [1:0]  Owner,
  output logic        Busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  ack_q, ack_d;
  logic [7:0]  q_q, q_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [2:0]  pick_s;
  logic [7:0]  q_sel_s;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Returns {found, index}: first set request after 'last', wrapping modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic       found;
    logic [1:0] sel;
    logic [1:0] idx;
    found = 1'b0;
    sel   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + i[1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = 4'b0000;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    q_sel_s = q_q;
    pick_s  = rr_pick(Req, last_q);
    case (state_q)
      ST_IDLE: begin
        if (pick_s[2]) begin
          state_d = ST_LOAD;
          grant_d = onehot(pick_s[1:0]);
          owner_d = pick_s[1:0];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        q_sel_s = Din[{owner_q, 3'b000} +: 8];
        ack_d   = onehot(owner_q);
        cnt_d   = HOLD_M1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if ((cnt_q == 4'd0) || !Req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = 4'b0000;
          last_d  = owner_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
      end
    endcase
    // Flush wins over a same-cycle load; the Ack is unaffected.
    q_d    = Flush ? 8'h00 : q_sel_s;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      ack_q   <= 4'b0000;
      q_q     <= 8'h00;
      owner_q <= 2'd3;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign Grant = grant_q;
  assign Ack   = ack_q;
  assign Q     = q_q;
  assign Owner = owner_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_latch_arbiter.sv
// Directed bench for latch_arbiter with HOLD=3; inputs change and outputs
// are sampled on the falling clock edge.
module tb_latch_arbiter;

  logic        CLK;
  logic        Clrn;
  logic [3:0]  Req;
  logic [31:0] Din;
  logic        Flush;
  logic [3:0]  Grant;
  logic [3:0]  Ack;
  logic [7:0]  Q;
  logic [1:0]  Owner;
  logic        Busy;

  int checks;
  int errors;

  latch_arbiter #(.HOLD(3)) dut (
    .CLK(CLK), .Clrn(Clrn), .Req(Req), .Din(Din), .Flush(Flush),
    .Grant(Grant), .Ack(Ack), .Q(Q), .Owner(Owner), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    Clrn  = 1'b0;
    Req   = 4'b0000;
    Din   = 32'h0;
    Flush = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    Clrn = 1'b1;
  endtask

  task automatic wait_grant(output logic [3:0] g, output logic ok);
    ok = 1'b0;
    g  = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Grant !== 4'b0000) begin
        g  = Grant;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Grant === 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Clrn  = 1'b0;
    Req   = 4'b0000;
    Din   = 32'h0;
    Flush = 1'b0;
    @(negedge CLK);
    checks++;
    if ({Grant, Ack, Q, Owner, Busy} !== {4'b0000, 4'b0000, 8'h00, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got G=%b A=%b Q=%h O=%0d B=%b", Grant, Ack, Q, Owner, Busy);
    end
    Clrn = 1'b1;
  endtask

  task automatic test_single();
    int gcount;
    do_reset();
    Req = 4'b0001;
    Din = 32'h000000A5;
    @(negedge CLK);
    checks++;
    if (Grant !== 4'b0001 || Busy !== 1'b1 || Owner !== 2'd0 || Ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_grant: got G=%b B=%b O=%0d A=%b expected 0001 1 0 0000", Grant, Busy, Owner, Ack);
    end
    gcount = 1;
    @(negedge CLK);
    checks++;
    if (Q !== 8'hA5 || Ack !== 4'b0001) begin
      errors++;
      $display("FAIL single_load: got Q=%h A=%b expected a5 0001", Q, Ack);
    end
    if (Grant === 4'b0001) gcount++;
    @(negedge CLK);
    checks++;
    if (Ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack_pulse: got A=%b expected 0000", Ack);
    end
    if (Grant === 4'b0001) gcount++;
    @(negedge CLK);
    if (Grant === 4'b0001) gcount++;
    @(negedge CLK);
    if (Grant === 4'b0001) gcount++;
    checks++;
    if (Busy !== 1'b0 || Grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_release: got G=%b B=%b expected 0000 0", Grant, Busy);
    end
    Req = 4'b0000;
    @(negedge CLK);
    if (Grant === 4'b0001) gcount++;
    checks++;
    if (gcount != 4) begin
      errors++;
      $display("FAIL single_grant_len: got %0d cycles expected 4", gcount);
    end
  endtask

  task automatic test_rotate();
    logic [3:0] exp_g;
    logic [7:0] exp_q;
    logic [31:0] bytes;
    do_reset();
    bytes = 32'h44332211;
    Din   = bytes;
    Req   = 4'b1111;
    for (int c = 0; c <= 20; c++) begin
      @(negedge CLK);
      exp_g = 4'b0001 << ((c / 5) % 4);
      exp_q = bytes[((c / 5) % 4) * 8 +: 8];
      if (c % 5 == 0) begin
        checks++;
        if (Grant !== exp_g) begin
          errors++;
          $display("FAIL rotate_grant c=%0d: got %b expected %b", c, Grant, exp_g);
        end
      end else if (c % 5 == 1) begin
        checks++;
        if (Q !== exp_q || Ack !== exp_g) begin
          errors++;
          $display("FAIL rotate_load c=%0d: got Q=%h A=%b expected %h %b", c, Q, Ack, exp_q, exp_g);
        end
      end else if (c % 5 == 4) begin
        checks++;
        if (Grant !== 4'b0000) begin
          errors++;
          $display("FAIL rotate_gap c=%0d: got %b expected 0000", c, Grant);
        end
      end
    end
    Req = 4'b0000;
  endtask

  task automatic test_rr_skip();
    logic [3:0] g;
    logic       ok;
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b1000;
    exp_seq[1] = 4'b0001;
    exp_seq[2] = 4'b0010;
    do_reset();
    Req = 4'b0100;
    wait_grant(g, ok);
    checks++;
    if (!ok || g !== 4'b0100) begin
      errors++;
      $display("FAIL rr_owner2: got %b ok=%b expected 0100", g, ok);
    end
    wait_idle(ok);
    Req = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== exp_seq[n]) begin
        errors++;
        $display("FAIL rr_skip_%0d: got %b ok=%b expected %b", n, g, ok, exp_seq[n]);
      end
      wait_idle(ok);
    end
    Req = 4'b0000;
  endtask

  task automatic test_early_release();
    do_reset();
    Din = 32'h00002211;
    Req = 4'b0011;
    @(negedge CLK);
    checks++;
    if (Grant !== 4'b0001) begin
      errors++;
      $display("FAIL early_grant: got %b expected 0001", Grant);
    end
    @(negedge CLK);
    Req = 4'b0010;
    @(negedge CLK);
    checks++;
    if (Grant !== 4'b0000 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL early_drop: got G=%b B=%b expected 0000 0", Grant, Busy);
    end
    @(negedge CLK);
    checks++;
    if (Grant !== 4'b0010 || Owner !== 2'd1) begin
      errors++;
      $display("FAIL early_next: got G=%b O=%0d expected 0010 1", Grant, Owner);
    end
    Req = 4'b0000;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_flush();
    do_reset();
    Din = 32'h000000FF;
    Req = 4'b0001;
    @(negedge CLK);
    Flush = 1'b1;
    @(negedge CLK);
    checks++;
    if (Q !== 8'h00 || Ack !== 4'b0001) begin
      errors++;
      $display("FAIL flush_load: got Q=%h A=%b expected 00 0001", Q, Ack);
    end
    Flush = 1'b0;
    Req   = 4'b0000;
    @(negedge CLK);
    Req = 4'b0001;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (Q !== 8'hFF) begin
      errors++;
      $display("FAIL flush_reload: got Q=%h expected ff", Q);
    end
    Req = 4'b0000;
    @(negedge CLK);
    checks++;
    if (Q !== 8'hFF || Busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_hold: got Q=%h B=%b expected ff 0", Q, Busy);
    end
    Flush = 1'b1;
    @(negedge CLK);
    checks++;
    if (Q !== 8'h00 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got Q=%h B=%b expected 00 0", Q, Busy);
    end
    Flush = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] g;
    logic       ok;
    do_reset();
    Din = 32'h44332211;
    Req = 4'b1111;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (Grant !== 4'b0001 || Q !== 8'h11) begin
      errors++;
      $display("FAIL areset_pre: got G=%b Q=%h expected 0001 11", Grant, Q);
    end
    #2;
    Clrn = 1'b0;
    #1;
    checks++;
    if ({Grant, Ack, Q, Owner, Busy} !== {4'b0000, 4'b0000, 8'h00, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL areset_now: got G=%b A=%b Q=%h O=%0d B=%b", Grant, Ack, Q, Owner, Busy);
    end
    @(negedge CLK);
    Clrn = 1'b1;
    wait_grant(g, ok);
    checks++;
    if (!ok || g !== 4'b0001) begin
      errors++;
      $display("FAIL areset_first: got %b ok=%b expected 0001", g, ok);
    end
    Req = 4'b0000;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Clrn  = 1'b0;
    Req   = 4'b0000;
    Din   = 32'h0;
    Flush = 1'b0;
    test_reset();
    test_single();
    test_rotate();
    test_rr_skip();
    test_early_release();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
